bist_signature_checker: RTL and testbench

Downstream result stage of the BIST datapath: consumes the MISR signature and the controller's `bist_end` pulse, captures the signature at the end of each run, and compares it to the golden value. It produces a registered pass/fail verdict and saturating run/fail statistics. Results go to the host through a valid/ack handshake. It replaces the combinational pass/fail term at the BIST top level with a sticky, acknowledged result.

---
 rtl/bist_pkg.sv | 17 +
 rtl/bist_sat_counter.sv | 31 +++
 rtl/bist_signature_checker.sv | 153 +++++++++++++++
 tb/tb_bist_signature_checker.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bist_pkg.sv
// Shared definitions for the BIST result stage: checker FSM states and the
// default widths / golden signature used by bist_signature_checker.
package bist_pkg;

  localparam int               BIST_SIG_W           = 8;
  localparam int               BIST_CNT_W           = 8;
  localparam int               BIST_TIMEOUT_CYCLES  = 64;
  localparam logic [7:0]       BIST_SIGNATURE_VALID = 8'h27;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_END = 2'd1,
    COMPARE  = 2'd2,
    REPORT   = 2'd3
  } chk_state_t;

endpackage

// File: rtl/bist_sat_counter.sv
// Saturating up-counter used for the run and fail statistics. It sticks at
// all-ones instead of wrapping. i_reset is an asynchronous active-low clear.
module bist_sat_counter
  import bist_pkg::*;
#(
  parameter int CNT_W = BIST_CNT_W
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;
  logic             w_saturated;

  assign w_saturated = &r_count;

  // Count requested increments until all-ones, then hold.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_count <= '0;
    end else if (i_inc && !w_saturated) begin
      // NOTE: sequential state uses <= so every register samples pre-edge values.
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/bist_signature_checker.sv
// BIST result stage. It captures the MISR signature at bist_end and compares
// it with the golden value. A sticky pass/fail result is held for the host
// until the host acknowledges it. Run/fail statistics saturate.
// Optional watchdog: define BIST_CHK_TIMEOUT_EN to abort a run that sees no
// bist_end within TIMEOUT_CYCLES cycles. Without it, WAIT_END waits forever.
module bist_signature_checker
  import bist_pkg::*;
#(
  parameter int               SIG_W           = BIST_SIG_W,
  parameter logic [SIG_W-1:0] SIGNATURE_VALID = SIG_W'(BIST_SIGNATURE_VALID),
  parameter int               CNT_W           = BIST_CNT_W,
  parameter int               TIMEOUT_CYCLES  = BIST_TIMEOUT_CYCLES
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_bist_start,
  input  logic             i_bist_end,
  input  logic [SIG_W-1:0] i_signature,
  input  logic             i_result_ack,
  output logic             o_busy,
  output logic             o_result_valid,
  output logic             o_pass_fail,
  output logic [SIG_W-1:0] o_captured_sig,
  output logic [CNT_W-1:0] o_run_count,
  output logic [CNT_W-1:0] o_fail_count,
  output logic             o_timeout
);

  chk_state_t       r_state;
  chk_state_t       w_next_state;
  logic             w_result_valid_next;
  logic             r_result_valid;
  logic             r_pass_fail;
  logic             r_timeout;
  logic [SIG_W-1:0] r_captured_sig;
  logic             w_timeout_hit;
  logic             w_sig_match;
  logic             w_run_inc;
  logic             w_fail_inc;

  // The match is an exact compare over every bit, not an AND-reduction.
  assign w_sig_match = (r_captured_sig == SIGNATURE_VALID);

`ifdef BIST_CHK_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] r_to_cnt;

  // Watchdog counts WAIT_END cycles with no bist_end. It restarts whenever
  // the FSM leaves WAIT_END.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_to_cnt <= '0;
    end else if (r_state != WAIT_END) begin
      r_to_cnt <= '0;
    end else if (!i_bist_end) begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  // A bist_end in the expiry cycle takes priority over the timeout.
  assign w_timeout_hit = (r_state == WAIT_END) && !i_bist_end &&
                         (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout_hit = 1'b0;
`endif

  // A finished run (compare or watchdog) always counts. A mismatch or
  // timeout also counts as a failure.
  assign w_run_inc  = (r_state == COMPARE) || w_timeout_hit;
  assign w_fail_inc = ((r_state == COMPARE) && !w_sig_match) || w_timeout_hit;

  // State register.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode. result_valid lags REPORT entry by one cycle, so an
  // ack in the first REPORT cycle is ignored.
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    w_next_state        = r_state;
    w_result_valid_next = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_bist_start) w_next_state = WAIT_END;
      end
      WAIT_END: begin
        if (i_bist_end)         w_next_state = COMPARE;
        else if (w_timeout_hit) w_next_state = REPORT;
      end
      COMPARE: begin
        w_next_state = REPORT;
      end
      REPORT: begin
        if (r_result_valid && i_result_ack) w_next_state        = IDLE;
        else                                w_next_state        = REPORT;
        if (!(r_result_valid && i_result_ack)) w_result_valid_next = 1'b1;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Result fields. They hold after the ack until the next compare or timeout.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_result_valid <= 1'b0;
      r_pass_fail    <= 1'b0;
      r_timeout      <= 1'b0;
      r_captured_sig <= '0;
    end else begin
      r_result_valid <= w_result_valid_next;
      if ((r_state == WAIT_END) && i_bist_end) begin
        r_captured_sig <= i_signature;
      end
      if (r_state == COMPARE) begin
        r_pass_fail <= w_sig_match;
        r_timeout   <= 1'b0;
      end else if (w_timeout_hit) begin
        r_pass_fail <= 1'b0;
        r_timeout   <= 1'b1;
      end
    end
  end

  bist_sat_counter #(.CNT_W(CNT_W)) u_run_cnt (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_inc   (w_run_inc),
    .o_count (o_run_count)
  );

  bist_sat_counter #(.CNT_W(CNT_W)) u_fail_cnt (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_inc   (w_fail_inc),
    .o_count (o_fail_count)
  );

  assign o_busy         = (r_state != IDLE);
  assign o_result_valid = r_result_valid;
  assign o_pass_fail    = r_pass_fail;
  assign o_captured_sig = r_captured_sig;
`ifdef BIST_CHK_TIMEOUT_EN
  assign o_timeout      = r_timeout;
`else
  assign o_timeout      = 1'b0;
`endif

endmodule

// File: tb/tb_bist_signature_checker.sv
// Testbench for bist_signature_checker. Stimulus pushes the expected result of
// each run into a queue. A monitor pops one entry and compares it each time
// result_valid rises. Inputs are driven and outputs sampled on the falling edge.
module tb_bist_signature_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       bend = 1'b0;
  logic       ack = 1'b0;
  logic [7:0] sig = 8'h00;

  logic       busy;
  logic       rv;
  logic       pf;
  logic [7:0] csig;
  logic [7:0] runs;
  logic [7:0] fails;
  logic       tmo;

  always #5 clk = ~clk;

  bist_signature_checker dut (
    .i_clock        (clk),
    .i_reset        (rst_n),
    .i_bist_start   (start),
    .i_bist_end     (bend),
    .i_signature    (sig),
    .i_result_ack   (ack),
    .o_busy         (busy),
    .o_result_valid (rv),
    .o_pass_fail    (pf),
    .o_captured_sig (csig),
    .o_run_count    (runs),
    .o_fail_count   (fails),
    .o_timeout      (tmo)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected result of one run.
  typedef struct {
    logic       pf;
    logic [7:0] sig;
    logic [7:0] runs;
    logic [7:0] fails;
    logic       to;
  } exp_t;

  exp_t       sb_q[$];
  exp_t       mon_e;
  int         m_runs = 0;
  int         m_fails = 0;
  logic [7:0] m_sig = 8'h00;

  // Build the expected result for a run ending with signature s, or for a
  // watchdog timeout. Counters saturate at 255. A timeout keeps the old signature.
  function automatic void push_result(input logic [7:0] s, input logic is_to);
    exp_t e;
    if (!is_to) m_sig = s;
    e.pf = !is_to && (s == 8'h27);
    m_runs = (m_runs < 255) ? m_runs + 1 : 255;
    if (!e.pf) m_fails = (m_fails < 255) ? m_fails + 1 : 255;
    e.sig   = m_sig;
    e.runs  = 8'(m_runs);
    e.fails = 8'(m_fails);
    e.to    = is_to;
    sb_q.push_back(e);
  endfunction

  // Monitor: score every rising edge of result_valid against the queue.
  logic rv_q = 1'b0;
  always @(negedge clk) begin
    if (rv && !rv_q) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_result: result_valid rose with no run pending (t=%0t)", $time);
      end else begin
        mon_e = sb_q.pop_front();
        check("sb_pass_fail", 32'(pf),    32'(mon_e.pf));
        check("sb_captured",  32'(csig),  32'(mon_e.sig));
        check("sb_run_count", 32'(runs),  32'(mon_e.runs));
        check("sb_fail_count",32'(fails), 32'(mon_e.fails));
        check("sb_timeout",   32'(tmo),   32'(mon_e.to));
      end
    end
    rv_q = rv;
  end

  // All tasks are entered just after a falling edge.
  task automatic start_run();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
  endtask

  // Present bist_end for one cycle. On return, edge N has sampled it.
  task automatic end_run(input logic [7:0] s);
    sig  = s;
    bend = 1'b1;
    push_result(s, 1'b0);
    @(negedge clk);
    bend = 1'b0;
  endtask

  // result_valid is low after edges N and N+1, and high after edge N+2.
  task automatic wait_latency();
    check("rv_after_N", 32'(rv), 32'd0);
    @(negedge clk);
    check("rv_after_N1", 32'(rv), 32'd0);
    @(negedge clk);
    check("rv_after_N2", 32'(rv), 32'd1);
  endtask

  task automatic ack_result();
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    check("rv_after_ack", 32'(rv), 32'd0);
    check("busy_after_ack", 32'(busy), 32'd0);
  endtask

  // Hard stop in case something hangs.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "tb watchdog");
  end

  initial begin
    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rv",   32'(rv),   32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_pf",    32'(pf),    32'd0);
    check("rst_sig",   32'(csig),  32'd0);
    check("rst_runs",  32'(runs),  32'd0);
    check("rst_fails", 32'(fails), 32'd0);
    check("rst_tmo",   32'(tmo),   32'd0);

    // A bist_end in IDLE is ignored.
    sig  = 8'h27;
    bend = 1'b1;
    @(negedge clk);
    bend = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_end_busy", 32'(busy), 32'd0);
    check("idle_end_rv",   32'(rv),   32'd0);
    check("idle_end_sig",  32'(csig), 32'd0);
    check("idle_end_runs", 32'(runs), 32'd0);

    // Passing run.
    start_run();
    @(negedge clk);
    end_run(8'h27);
    wait_latency();
    ack_result();

    // Failing run that holds its result for 10 cycles without an ack.
    start_run();
    end_run(8'h26);
    wait_latency();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_rv",  32'(rv),   32'd1);
      check("hold_sig", 32'(csig), 32'h26);
    end
    ack_result();
    check("post_ack_pf",  32'(pf),   32'd0);
    check("post_ack_sig", 32'(csig), 32'h26);

    // A bist_end in the same cycle as start is ignored. The run waits for
    // the next bist_end. 8'h2F contains every bit of 8'h27, so it must
    // still fail the exact compare.
    start = 1'b1;
    bend  = 1'b1;
    sig   = 8'h27;
    @(negedge clk);
    start = 1'b0;
    bend  = 1'b0;
    repeat (3) @(negedge clk);
    check("same_cycle_busy", 32'(busy), 32'd1);
    check("same_cycle_rv",   32'(rv),   32'd0);
    check("same_cycle_sig",  32'(csig), 32'h26);
    end_run(8'h2F);
    // An ack sampled while result_valid is still low has no effect.
    check("early_rv_N", 32'(rv), 32'd0);
    @(negedge clk);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    check("early_ack_rv", 32'(rv), 32'd1);
    @(negedge clk);
    check("early_ack_rv_hold", 32'(rv),   32'd1);
    check("early_ack_busy",    32'(busy), 32'd1);
    // A start in the same cycle as the ack does not begin a new run.
    ack   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    ack   = 1'b0;
    start = 1'b0;
    check("ack_start_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    check("ack_start_idle", 32'(busy), 32'd0);

    // Reset mid-run aborts immediately and clears the counters.
    start_run();
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy",  32'(busy),  32'd0);
    check("midrst_runs",  32'(runs),  32'd0);
    check("midrst_fails", 32'(fails), 32'd0);
    check("midrst_sig",   32'(csig),  32'd0);
    m_runs  = 0;
    m_fails = 0;
    m_sig   = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    sig   = 8'h27;
    bend  = 1'b1;
    @(negedge clk);
    bend = 1'b0;
    repeat (4) @(negedge clk);
    check("midrst_no_rv",   32'(rv),   32'd0);
    check("midrst_no_busy", 32'(busy), 32'd0);

    // Watchdog behaviour.
    start_run();
`ifdef BIST_CHK_TIMEOUT_EN
    repeat (63) @(negedge clk);
    check("to_pre_busy", 32'(busy), 32'd1);
    check("to_pre_tmo",  32'(tmo),  32'd0);
    push_result(8'h00, 1'b1);
    @(negedge clk);
    check("to_fire_tmo", 32'(tmo), 32'd1);
    check("to_fire_rv",  32'(rv),  32'd0);
    @(negedge clk);
    check("to_rv", 32'(rv), 32'd1);
    ack_result();
    check("to_hold_tmo", 32'(tmo), 32'd1);
`else
    repeat (1000) @(negedge clk);
    check("nowd_busy", 32'(busy), 32'd1);
    check("nowd_rv",   32'(rv),   32'd0);
    check("nowd_tmo",  32'(tmo),  32'd0);
    end_run(8'h27);
    wait_latency();
    ack_result();
`endif

    // Saturation: 260 failing runs push both counters to all-ones.
    for (int i = 0; i < 260; i++) begin
      start_run();
      end_run((i % 2 == 0) ? 8'h26 : 8'hA7);
      repeat (2) @(negedge clk);
      ack_result();
    end
    check("sat_runs",  32'(runs),  32'hFF);
    check("sat_fails", 32'(fails), 32'hFF);
    check("sat_tmo",   32'(tmo),   32'd0);

    repeat (3) @(negedge clk);
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
